// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one 4-bit ALU between two requesters.
// Each operation is held for LAT execute cycles, then returned on the owner's response channel.
module alu_share_ctrl #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req1_a,
    input  logic [3:0] req0_b,
    input  logic [3:0] req1_b,
    input  logic [1:0] req0_op,
    input  logic [1:0] req1_op,
    output logic       rsp0_valid,
    output logic       rsp1_valid,
    input  logic       rsp0_ready,
    input  logic       rsp1_ready,
    output logic [7:0] rsp0_f,
    output logic [7:0] rsp1_f,
    output logic       busy,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    localparam logic [2:0] CNT_LOAD = 3'(LAT - 1);

    state_t      state, state_nxt;
    logic        prio;
    logic        owner;
    logic [2:0]  cnt;
    logic        win1;
    logic        accept, done, rsp_hs;
    logic [3:0]  a_p0, b_p0;
    logic [1:0]  op_p0;
    logic [7:0]  res_p1;

    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
        logic signed [7:0] sa;
        logic signed [7:0] sb;
        sa = signed'({4'b0000, a});
        sb = signed'({4'b0000, b});
        case (op)
            2'b00:   alu_f = {4'b0000, a} + {4'b0000, b};
            2'b01:   alu_f = sa - sb;
            2'b10:   alu_f = {4'b0000, a} * {4'b0000, b};
            default: alu_f = (a < b) ? 8'h01 : ((a > b) ? 8'h02 : 8'h00);
        endcase
    endfunction

    // Requester 1 wins when it is alone or when both are pending and it holds priority.
    assign win1 = req1_valid && (!req0_valid || prio);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        rsp_hs    = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 3'd0) begin
                    done      = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (owner ? rsp1_ready : rsp0_ready) begin
                    rsp_hs    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            prio     <= 1'b0;
            owner    <= 1'b0;
            cnt      <= 3'd0;
            res_p1   <= 8'h00;
            op_count <= 8'h00;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner <= win1;
                cnt   <= CNT_LOAD;
            end else if (state == EXEC && !done) begin
                cnt <= cnt - 3'd1;
            end
            if (done) begin
                res_p1 <= alu_f(a_p0, b_p0, op_p0);
            end
            if (rsp_hs) begin
                prio     <= ~owner;
                op_count <= op_count + 8'd1;
            end
        end
    end

    // Operand capture stage: data only, qualified by the accept strobe.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0  <= win1 ? req1_a  : req0_a;
            b_p0  <= win1 ? req1_b  : req0_b;
            op_p0 <= win1 ? req1_op : req0_op;
        end
    end

    assign req0_ready = (state == IDLE) && req0_valid && !win1;
    assign req1_ready = (state == IDLE) && win1;
    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) && owner;
    assign rsp0_f     = res_p1;
    assign rsp1_f     = res_p1;
    assign busy       = (state != IDLE);

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequenced, arbitrated front end for the team's 4-bit ALU datapath. Two independent requesters each submit one operation at a time over a valid/ready request channel. The block grants the single internal ALU round-robin, holds the operation for a programmable execute latency, and returns the 8-bit result on the winner's valid/ready response channel. It sits between the requesting control units and the ALU, so neither requester needs to know the other exists.

## Interface
Parameters:
- LAT, 1, execute cycles per operation; legal range 1..8.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid / req1_valid  input  1  requester N has an operation pending.
- req0_ready / req1_ready  output  1  operation accepted this cycle.
- req0_a / req1_a  input  4  operand A.
- req0_b / req1_b  input  4  operand B.
- req0_op / req1_op  input  2  opcode: 00 add, 01 sub, 10 mul, 11 compare.
- rsp0_valid / rsp1_valid  output  1  result for requester N is available.
- rsp0_ready / rsp1_ready  input  1  requester N consumes the result.
- rsp0_f / rsp1_f  output  8  result; both ports are driven from one shared result register.
- busy  output  1  high whenever the state is not IDLE.
- op_count  output  8  completed response handshakes; wraps from 255 to 0.

## Operation
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- Round-robin pointer `prio`: reset value 0.
- IDLE grant rule:
  - If only one reqN_valid is high, that requester wins.
  - If both are high, requester `prio` wins.
- reqN_ready is combinational: it equals (state==IDLE) && reqN_valid && (winner==N). At most one ready is high per cycle.
- On acceptance (valid & ready):
  - capture a, b and op into operand registers;
  - record the owner;
  - load the latency counter with LAT-1;
  - go to EXEC.
- EXEC:
  - decrement the counter each cycle;
  - when it reaches 0, load the ALU output into the result register and go to RESP.
- RESP:
  - rsp<owner>_valid is high; the other rspN_valid stays low.
  - On rsp<owner>_ready: go to IDLE, set prio to the requester that was not the owner, and increment op_count.
- Arithmetic (8-bit result F):
  - add: zero-extended A+B, range 0..30.
  - sub: A-B in 8-bit two's complement, so 3-5 = 8'hFE.
  - mul: A*B, range 0..225.
  - compare: 8'h01 if A<B, 8'h02 if A>B, 8'h00 if equal.
- Requester rules:
  - Once reqN_valid is raised, the requester holds valid and its operands stable until ready.
  - Requests from the non-owner remain pending and are not accepted during EXEC or RESP.
- rspN_f holds the last result until the next EXEC completion; it is meaningful only while rspN_valid is high.
- Reset asserted mid-operation (EXEC or RESP) drops the in-flight operation with no response. All state returns to reset values immediately, independent of clk.

## Timing
- Reset values: req0_ready=req1_ready=0 (no valid requests during reset), rsp0_valid=rsp1_valid=0, rsp0_f=rsp1_f=8'h00, busy=0, op_count=0, prio=0.
- Acceptance edge at cycle t. The block is in EXEC for cycles t+1..t+LAT. rsp_valid is high from cycle t+LAT+1.
- If rsp_ready is high in the first RESP cycle, the block is in IDLE at t+LAT+2 and can accept in that cycle.
- Minimum acceptance-to-acceptance spacing is LAT+2 cycles; with LAT=1, one operation every 3 cycles.
- rsp_valid stays high and rsp_f stays stable indefinitely while rsp_ready is low (backpressure).
- rsp_ready asserted while rsp_valid is low has no effect. The non-owner's rsp_ready is ignored.
- op_count updates on the same edge as the response handshake.

## Test plan
- Reset then a single request, LAT=1: req0 a=7, b=9, op=00 accepted at cycle 0 -> rsp0_valid at cycle 2 with rsp0_f=8'h10; rsp1_valid stays 0; op_count=1 after the handshake.
- Arithmetic corners:
  - sub 3-5 -> 8'hFE;
  - mul 15*15 -> 8'hE1;
  - compare 2,9 -> 8'h01; 9,2 -> 8'h02; 6,6 -> 8'h00.
- Contention: both valid continuously in IDLE after reset -> grants alternate 0,1,0,1. Each response goes only to its owner; never two readies in one cycle.
- Backpressure: hold rsp1_ready=0 for 5 cycles -> rsp1_valid and rsp1_f stay stable, busy=1, req0 is not accepted; release rsp1_ready -> IDLE on the next edge, and req0 is accepted in that IDLE cycle.
- LAT=4: acceptance at cycle 0 -> busy from cycle 1, rsp_valid first high at cycle 5. Back-to-back accepts with rsp_ready tied high are 6 cycles apart.
- Drop rst_n during EXEC -> all outputs return to reset values without waiting for a clock edge, and no response appears for the dropped operation. Count 256 completions -> op_count wraps to 0.
